slot_rr_arbiter: RTL
====================

SLOT_RR_ARBITER -- requirements
Module: slot_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the single-entry slot (2..16).
REQ-002 Parameter OWNER_W, default 2, width of the owner ID; SHALL equal ceil(log2(N_REQ)).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles (1..65535); used only when HOLD_TIMEOUT_EN is defined.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 io_req_valid  input  N_REQ  per-requester request to occupy the slot.
REQ-007 io_req_ready  output  N_REQ  per-requester grant; one-hot or zero.
REQ-008 io_deq_valid  output  1  slot occupied.
REQ-009 io_deq_ready  input  1  consumer releases the slot.
REQ-010 io_deq_owner  output  OWNER_W  index of the requester holding the slot; valid while io_deq_valid=1.
REQ-011 io_timeout  output  1  one-cycle pulse on watchdog release; tied 0 when HOLD_TIMEOUT_EN is undefined.

Function
REQ-012 The FSM SHALL have two states: EMPTY and HELD.
REQ-013 In EMPTY, io_req_ready SHALL combinationally assert exactly one bit: the first set bit of io_req_valid at or after rr_ptr, searching upward modulo N_REQ.
REQ-014 In EMPTY with io_req_valid=0, io_req_ready SHALL be 0.
REQ-015 In HELD, io_req_ready SHALL be 0.
REQ-016 An enqueue fires when io_req_valid[i] and io_req_ready[i] are both 1 at a clock edge; the next state SHALL be HELD and owner SHALL be set to i.
REQ-017 On an enqueue, rr_ptr SHALL update to (i+1) mod N_REQ.
REQ-018 io_deq_valid SHALL be 1 exactly when the state is HELD; latency from enqueue to io_deq_valid is 1 cycle.
REQ-019 A dequeue fires when HELD and io_deq_ready=1; the next state SHALL be EMPTY, and owner and rr_ptr SHALL be unchanged.
REQ-020 Enqueue and dequeue SHALL never fire in the same cycle.
REQ-021 No bypass: after a release, the next grant SHALL occur no earlier than the cycle following the release.
REQ-022 Back-to-back throughput SHALL be one grant per 2 cycles at best.
REQ-023 A requester dropping io_req_valid before the handshake SHALL lose the grant that cycle, and arbitration SHALL re-evaluate combinationally.
REQ-024 io_deq_ready while EMPTY SHALL have no effect.

Reset
REQ-025 While reset=0, the block SHALL be in EMPTY with rr_ptr=0, owner=0 and hold_cnt=0.
REQ-026 While reset=0, outputs SHALL be io_deq_valid=0, io_deq_owner=0, io_timeout=0 and io_req_ready=0.
REQ-027 Reset asserted mid-HELD SHALL discard the slot immediately, without waiting for a clock edge.
REQ-028 Reset deassertion is assumed synchronised externally; the first grant is possible in the first cycle after deassertion.

Configuration
REQ-029 Macro SLOT_RR_ARBITER_HOLD_TIMEOUT_EN SHALL compile in a watchdog.
REQ-030 With the macro: hold_cnt SHALL clear on enqueue and increment each HELD cycle without a dequeue.
REQ-031 With the macro: when hold_cnt reaches TIMEOUT_CYCLES-1 while HELD with io_deq_ready=0, the next state SHALL be EMPTY and io_timeout SHALL pulse high for that edge's following cycle.
REQ-032 With the macro: a dequeue on the same cycle as timeout expiry SHALL take precedence, with io_timeout=0.
REQ-033 Without the macro: there SHALL be no hold_cnt register, io_timeout SHALL be constant 0, and the slot SHALL be held indefinitely.

Verification
REQ-034 Reset release, io_req_valid=4'b1111 -> cycle0 io_req_ready=4'b0001; after release, next grants are 4'b0010, 4'b0100, 4'b1000, then 4'b0001.
REQ-035 rr_ptr=2, io_req_valid=4'b0011 -> io_req_ready=4'b0001 (wrap-around), owner=0, then rr_ptr=1.
REQ-036 Enqueue at cycle N, io_deq_ready held 1 -> io_deq_valid=1 in N+1, 0 in N+2, next io_req_ready in N+2; never enqueue and dequeue in one cycle.
REQ-037 Reset driven low mid-HELD, between edges -> io_deq_valid=0 immediately; after release, requester 0 has highest priority.
REQ-038 With the macro, TIMEOUT_CYCLES=3, io_deq_ready=0 -> io_deq_valid high for 3 cycles, then io_timeout=1 for one cycle with io_deq_valid=0.
REQ-039 With the macro, dequeue on the expiry cycle -> io_timeout=0; without the macro, slot held 1000 cycles with io_timeout=0.

Source files
------------

// File: rtl/slot_rr_arbiter.sv
// Single-entry slot shared by N_REQ requesters with round-robin grant.
// Optional hold watchdog: define SLOT_RR_ARBITER_HOLD_TIMEOUT_EN.
module slot_rr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int OWNER_W        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   io_req_valid,
  output logic [N_REQ-1:0]   io_req_ready,
  output logic               io_deq_valid,
  input  logic               io_deq_ready,
  output logic [OWNER_W-1:0] io_deq_owner,
  output logic               io_timeout
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("slot_rr_arbiter: N_REQ out of range");
  end
  if (OWNER_W != $clog2(N_REQ)) begin : g_bad_owner_w
    $error("slot_rr_arbiter: OWNER_W must equal clog2(N_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("slot_rr_arbiter: TIMEOUT_CYCLES out of range");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t             state;
  logic [OWNER_W-1:0] rr_ptr;
  logic [OWNER_W-1:0] owner;
  logic [N_REQ-1:0]   pick;
  logic               pick_any;
  logic [OWNER_W-1:0] pick_idx;
  logic [OWNER_W-1:0] pick_next;

  // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    idx       = 0;
    pick      = '0;
    pick_any  = 1'b0;
    pick_idx  = '0;
    pick_next = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!pick_any && io_req_valid[idx]) begin
        pick_any     = 1'b1;
        pick[idx]    = 1'b1;
        pick_idx     = OWNER_W'(idx);
        pick_next    = OWNER_W'((idx + 1) % N_REQ);
      end
    end
  end

  // Gate with reset so no grant is shown while reset is held.
  assign io_req_ready = (state == EMPTY && reset) ? pick : '0;
  assign io_deq_valid = (state == HELD);
  assign io_deq_owner = owner;

`ifdef SLOT_RR_ARBITER_HOLD_TIMEOUT_EN
  logic [15:0] hold_cnt;
  logic        timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      rr_ptr    <= '0;
      owner     <= '0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        EMPTY: begin
          if (pick_any) begin
            state    <= HELD;
            owner    <= pick_idx;
            rr_ptr   <= pick_next;
            hold_cnt <= '0;
          end
        end
        HELD: begin
          // A release by the consumer wins over a coincident expiry.
          if (io_deq_ready) begin
            state <= EMPTY;
          end else if (hold_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state     <= EMPTY;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign io_timeout = timeout_q;
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (pick_any) begin
            state  <= HELD;
            owner  <= pick_idx;
            rr_ptr <= pick_next;
          end
        end
        HELD: begin
          if (io_deq_ready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign io_timeout = 1'b0;
`endif

endmodule
